// File: rtl/opamp_trim_pkg.sv
// opamp_trim_pkg: shared state type and helper functions for the op-amp offset-trim sequencer.
package opamp_trim_pkg;
  typedef enum logic [2:0] {IDLE, PWRUP, SETTLE, SAMPLE, DONE} state_t;
  function automatic int midscale(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic int cal_latency(input int w, input int p, input int s, input bit vote);
    return p + w * (s + (vote ? 3 : 1));
  endfunction
endpackage

// File: rtl/opamp_trim_sync.sv
// opamp_trim_sync: two-flop synchronizer for the asynchronous comparator output.
module opamp_trim_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] r_ff;
  always_ff @(posedge clk)
    if (rst) r_ff <= '0;
    else r_ff <= {r_ff[0], d};
  assign q = r_ff[1];
endmodule

// File: rtl/opamp_trim_ctrl.sv
// opamp_trim_ctrl: SAR offset-trim calibration sequencer for the on-die op-amp.
// Define OPAMP_TRIM_VOTE_EN to decide each bit by a 3-sample majority vote.
module opamp_trim_ctrl
  import opamp_trim_pkg::*;
#(
  parameter int TRIM_W        = 6,
  parameter int PWRUP_CYCLES  = 64,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic              cmp_in,
  input  logic              trim_load,
  input  logic [TRIM_W-1:0] trim_wdata,
  output logic              amp_en,
  output logic              cal_sw,
  output logic [TRIM_W-1:0] trim_code,
  output logic              busy,
  output logic              done,
  output logic              sat
);
  localparam int CW = $clog2((PWRUP_CYCLES > SETTLE_CYCLES ? PWRUP_CYCLES : SETTLE_CYCLES) + 1);
  localparam logic [TRIM_W-1:0] MID = TRIM_W'(midscale(TRIM_W));
`ifdef OPAMP_TRIM_VOTE_EN
  localparam logic [CW-1:0] SAMP_LOAD = CW'(2);
`else
  localparam logic [CW-1:0] SAMP_LOAD = '0;
`endif
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [TRIM_W-1:0] r_trial, w_trial, r_mask, w_mask, r_result, w_result, w_fin;
  logic r_done, w_done, r_sat, w_sat, w_cmp, w_dec, w_busy;
  opamp_trim_sync u_sync (.clk(clk), .rst(rst), .d(cmp_in), .q(w_cmp));
`ifdef OPAMP_TRIM_VOTE_EN
  logic [1:0] r_vote;
  always_ff @(posedge clk)
    if (rst) r_vote <= '0;
    else r_vote <= {r_vote[0], w_cmp};
  assign w_dec = (r_vote[1] & r_vote[0]) | (r_vote[1] & w_cmp) | (r_vote[0] & w_cmp);
`else
  assign w_dec = w_cmp;
`endif
  // r_mask is the one-hot bit currently under test
  assign w_fin = w_dec ? r_trial : r_trial & ~r_mask;
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt - CW'(1);
    w_trial  = r_trial;
    w_mask   = r_mask;
    w_result = r_result;
    w_done   = r_done;
    w_sat    = r_sat;
    if (!ena) w_state = IDLE;
    else
      unique case (r_state)
        IDLE, DONE:
          if (start) begin
            w_state = PWRUP;
            w_cnt   = CW'(PWRUP_CYCLES - 1);
            w_trial = MID;
            w_mask  = MID;
            w_done  = 1'b0;
            w_sat   = 1'b0;
          end else if (trim_load) begin
            w_result = trim_wdata;
            w_done   = 1'b0;
          end
        PWRUP:
          if (r_cnt == '0) begin
            w_state = SETTLE;
            w_cnt   = CW'(SETTLE_CYCLES - 1);
          end
        SETTLE:
          if (r_cnt == '0) begin
            w_state = SAMPLE;
            w_cnt   = SAMP_LOAD;
          end
        SAMPLE:
          if (r_cnt == '0) begin
            w_trial = w_fin | (r_mask >> 1);
            w_mask  = r_mask >> 1;
            w_cnt   = CW'(SETTLE_CYCLES - 1);
            w_state = r_mask[0] ? DONE : SETTLE;
            if (r_mask[0]) begin
              w_result = w_fin;
              w_done   = 1'b1;
              w_sat    = (w_fin == '0) || (&w_fin);
            end
          end
        default: w_state = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_trial  <= MID;
      r_mask   <= MID;
      r_result <= MID;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_trial  <= w_trial;
      r_mask   <= w_mask;
      r_result <= w_result;
      r_done   <= w_done;
      r_sat    <= w_sat;
    end
  assign w_busy    = r_state inside {PWRUP, SETTLE, SAMPLE};
  assign busy      = w_busy;
  assign cal_sw    = w_busy;
  assign amp_en    = r_state != IDLE;
  assign trim_code = w_busy ? r_trial : r_result;
  assign done      = r_done;
  assign sat       = r_sat;
endmodule

// File: tb/tb_opamp_trim_ctrl.sv
// tb_opamp_trim_ctrl: randomized scoreboard bench for the offset-trim sequencer.
module tb_opamp_trim_ctrl;
  localparam int W = 6, P = 8, S = 4;
`ifdef OPAMP_TRIM_VOTE_EN
  localparam int NS = 3;
`else
  localparam int NS = 1;
`endif
  localparam int LAT = P + W * (S + NS);
  typedef struct packed {
    logic [W-1:0][W-1:0] tr;
    logic [W-1:0]        res;
    logic                sat;
    int                  done_cyc;
  } exp_t;
  logic clk = 0, rst = 1, ena = 0, start = 0, trim_load = 0, glitch = 0;
  logic [W-1:0] trim_wdata = '0;
  logic cmp_in, amp_en, cal_sw, busy, done, sat;
  logic [W-1:0] trim_code;
  int mode = 0, thr = 0, cyc = 0, tests = 0, fails = 0;
  exp_t sb[$];
  logic [W-1:0] seen[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign cmp_in = glitch ^ (mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : (int'(trim_code) <= thr));
  opamp_trim_ctrl #(.TRIM_W(W), .PWRUP_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .cmp_in(cmp_in),
    .trim_load(trim_load), .trim_wdata(trim_wdata), .amp_en(amp_en), .cal_sw(cal_sw),
    .trim_code(trim_code), .busy(busy), .done(done), .sat(sat)
  );
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic bit mcmp(input int code);
    return mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : code <= thr;
  endfunction
  // binary search: keep the largest lower bound the comparator accepts
  function automatic exp_t model();
    exp_t e;
    int lo = 0;
    e = '0;
    for (int b = W - 1; b >= 0; b--) begin
      e.tr[W-1-b] = W'(lo + (1 << b));
      if (mcmp(lo + (1 << b))) lo += 1 << b;
    end
    e.res = W'(lo);
    e.sat = (lo == 0) || (lo == (1 << W) - 1);
    return e;
  endfunction
  logic p_busy = 0, p_done = 0;
  logic [W-1:0] last = '0;
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1 && p_busy !== 1'b1) begin
      seen.delete();
      seen.push_back(trim_code);
      last = trim_code;
    end else if (busy === 1'b1 && trim_code !== last) begin
      seen.push_back(trim_code);
      last = trim_code;
    end
    if (done === 1'b1 && p_done !== 1'b1) begin
      chk("sb_has_entry", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("n_trials", seen.size(), W);
        for (int i = 0; i < W; i++)
          chk($sformatf("trial%0d", i), i < seen.size() ? int'(seen[i]) : -1, int'(e.tr[i]));
        chk("result", trim_code, e.res);
        chk("sat", sat, e.sat);
        chk("done_cycle", cyc, e.done_cyc);
        chk("amp_en_done", amp_en, 1);
        chk("cal_sw_done", cal_sw, 0);
        chk("busy_done", busy, 0);
      end
    end
    p_busy = busy;
    p_done = done;
  end
  task automatic run_cal(input int m, input int t, input bit poke, input bit glt);
    exp_t e;
    int n;
    mode = m;
    thr = t;
    e = model();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    e.done_cyc = cyc + LAT;
    sb.push_back(e);
    if (glt) begin
      repeat (P + S - 2) @(posedge clk);
      #1 glitch = 1;
      @(posedge clk); #1 glitch = 0;
    end
    if (poke) begin
      repeat ($urandom_range(1, LAT - 4)) @(posedge clk);
      #1 start = 1; trim_load = 1; trim_wdata = W'($urandom);
      @(posedge clk); #1 start = 0; trim_load = 0;
    end
    n = 0;
    while (done !== 1'b1 && n < LAT + 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", int'(done === 1'b1), 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trim_code", trim_code, 32);
    chk("rst_amp_en", amp_en, 0);
    chk("rst_cal_sw", cal_sw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    rst = 0;
    ena = 1;
    run_cal(0, 45, 0, 0);
    run_cal(1, 0, 0, 0);
    run_cal(2, 0, 0, 0);
    @(posedge clk); #1 trim_load = 1; trim_wdata = 20;
    @(posedge clk); #1 trim_load = 0;
    chk("load_trim_code", trim_code, 20);
    chk("load_done", done, 0);
    mode = 0; thr = 45;
    @(posedge clk); #1 start = 1; trim_load = 1; trim_wdata = 7;
    @(posedge clk); #1 start = 0; trim_load = 0;
    chk("start_wins_busy", busy, 1);
    repeat (P + 2 * (S + NS)) @(posedge clk);
    #1;
    chk("bit3_trial", trim_code, 40);
    ena = 0;
    @(posedge clk); #1;
    chk("abort_trim_code", trim_code, 20);
    chk("abort_amp_en", amp_en, 0);
    chk("abort_cal_sw", cal_sw, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sat", sat, 0);
    ena = 1;
`ifdef OPAMP_TRIM_VOTE_EN
    run_cal(0, 45, 0, 1);
`endif
    run_cal(0, 45, 1, 0);
    for (int k = 0; k < 10; k++)
      run_cal($urandom_range(0, 7) == 0 ? 1 + int'($urandom_range(0, 1)) : 0,
              int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 0);
    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
